// File: rtl/alu_regfiles.sv
// -----------------------------------------------------------------------------
// alu_regfiles
//   Four-entry register file feeding an eight-function ALU. Each instruction
//   reads two source registers and presents the ALU result combinationally on
//   outputData. The result is written to the destination register on the first
//   rising clock edge at which countOp differs from the last committed tag, so
//   holding a tag steady never writes twice.
//
// Parameters
//   WORD_SIZE    datapath width (default 16)
//   RESET_VALUE  value loaded into every register on reset (default 16'h0010)
//
// Ports
//   clk           in   1          rising-edge clock
//   reset_n       in   1          asynchronous active-low reset
//   countOp       in   8          instruction tag; a change marks a new instruction
//   functionCode  in   3          ALU operation select
//   readReg1      in   2          source A index
//   readReg2      in   2          source B index (unused by unary operations)
//   writeReg      in   2          destination index
//   outputData    out  WORD_SIZE  combinational ALU result
// -----------------------------------------------------------------------------
module alu_regfiles #(
  parameter int                   WORD_SIZE   = 16,
  parameter logic [WORD_SIZE-1:0] RESET_VALUE = WORD_SIZE'(16'h0010)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           countOp,
  input  logic [2:0]           functionCode,
  input  logic [1:0]           readReg1,
  input  logic [1:0]           readReg2,
  input  logic [1:0]           writeReg,
  output logic [WORD_SIZE-1:0] outputData
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_ORR = 3'b011,
    OP_NOT = 3'b100,
    OP_TCP = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } aluOp_e;

  localparam logic [WORD_SIZE-1:0] ONE = WORD_SIZE'(1);

  logic [WORD_SIZE-1:0] regFile [4];
  logic [7:0]           last_tag;
  logic [WORD_SIZE-1:0] opA;
  logic [WORD_SIZE-1:0] opB;
  logic [WORD_SIZE-1:0] aluResult;
  logic                 newInstr;

  // Read ports are purely combinational, so a source that is also the
  // destination supplies its pre-write value until the commit edge.
  assign opA = regFile[readReg1];
  assign opB = regFile[readReg2];

  // Unary operations never reference opB, so an unknown readReg2 cannot
  // propagate into their result.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch
    // can be inferred even if the case is later edited.
    aluResult = '0;
    case (aluOp_e'(functionCode))
      OP_ADD: aluResult = opA + opB;
      OP_SUB: aluResult = opA - opB;
      OP_AND: aluResult = opA & opB;
      OP_ORR: aluResult = opA | opB;
      OP_NOT: aluResult = ~opA;
      OP_TCP: aluResult = (~opA) + ONE;
      OP_SHL: aluResult = {opA[WORD_SIZE-2:0], 1'b0};
      OP_SHR: aluResult = {opA[WORD_SIZE-1], opA[WORD_SIZE-1:1]};
      default: aluResult = '0;
    endcase
  end

  assign outputData = aluResult;

  // A tag different from the last committed one is a fresh instruction;
  // wrap from 8'hff to 8'h00 is just another change.
  assign newInstr = (countOp != last_tag);

  // NOTE: the register file is four flops, not a RAM macro, so it takes the
  // asynchronous reset like any other state; a reset between edges therefore
  // also cancels whatever write was pending for the next edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        regFile[i] <= RESET_VALUE;
      end
      last_tag <= 8'h00;
    end else if (newInstr) begin
      // NOTE: non-blocking assignments let every read in this edge see the
      // old register values, matching the pre-write operand rule.
      regFile[writeReg] <= aluResult;
      last_tag          <= countOp;
    end
  end

endmodule

// File: tb/tb_alu_regfiles.sv
// -----------------------------------------------------------------------------
// tb_alu_regfiles
//   Self-checking bench for alu_regfiles. A behavioural model (register array,
//   last tag, arithmetic-only ALU) tracks the expected state. Directed steps
//   walk the documented instruction sequences, then a randomized run covers
//   tag holds and the 8'hff -> 8'h00 wrap.
// -----------------------------------------------------------------------------
module tb_alu_regfiles;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  countOp;
  logic [2:0]  functionCode;
  logic [1:0]  readReg1;
  logic [1:0]  readReg2;
  logic [1:0]  writeReg;
  logic [15:0] outputData;

  int total = 0;
  int bad   = 0;

  logic [15:0] mRegs [4];
  logic [7:0]  mTag;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, ORR = 3'd3,
                         NOT_ = 3'd4, TCP = 3'd5, SHL = 3'd6, SHR = 3'd7;

  alu_regfiles dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .countOp      (countOp),
    .functionCode (functionCode),
    .readReg1     (readReg1),
    .readReg2     (readReg2),
    .writeReg     (writeReg),
    .outputData   (outputData)
  );

  always #5 clk = ~clk;

  // Reference ALU written as plain modular arithmetic on 16-bit values.
  function automatic logic [15:0] refAlu(input logic [2:0] fc,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
    int unsigned ua, ub, r;
    ua = a;
    ub = b;
    case (fc)
      ADD:     r = (ua + ub) % 65536;
      SUB:     r = (ua + 65536 - ub) % 65536;
      AND_:    r = ua & ub;
      ORR:     r = ua | ub;
      NOT_:    r = 65535 - ua;
      TCP:     r = (65536 - ua) % 65536;
      SHL:     r = (ua * 2) % 65536;
      default: r = ua / 2 + ((ua >= 32768) ? 32768 : 0);
    endcase
    return r[15:0];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 4; i++) mRegs[i] = 16'h0010;
    mTag = 8'h00;
  endtask

  task automatic check(input string name, input logic [15:0] obs,
                       input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One instruction: drive after the rising edge, check at the falling edge,
  // then let the model commit as the DUT will on the next rising edge.
  task automatic step(input logic [7:0] tag, input logic [2:0] fc,
                      input logic [1:0] ra, input logic [1:0] rb,
                      input logic [1:0] wr, input logic [15:0] exp,
                      input bit useExp, input string name);
    logic [15:0] res;
    @(posedge clk);
    #1;
    countOp      = tag;
    functionCode = fc;
    readReg1     = ra;
    readReg2     = rb;
    writeReg     = wr;
    @(negedge clk);
    res = refAlu(fc, mRegs[ra], mRegs[rb]);
    if (useExp) check(name, outputData, exp);
    check({name, "/model"}, outputData, res);
    if (tag != mTag) begin
      mRegs[wr] = res;
      mTag      = tag;
    end
  endtask

  // Reads every register through ORR rX,rX without changing the tag, so no
  // write can happen while peeking.
  task automatic peekAll(input string name);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      functionCode = ORR;
      readReg1     = 2'(i);
      readReg2     = 2'(i);
      #1;
      check($sformatf("%s/r%0d", name, i), outputData, mRegs[i]);
    end
  endtask

  initial begin
    logic [7:0]  tag;
    logic [2:0]  fc;
    logic [1:0]  ra, rb, wr;

    reset_n      = 1'b0;
    countOp      = 8'h00;
    functionCode = ADD;
    readReg1     = 2'd0;
    readReg2     = 2'd1;
    writeReg     = 2'd0;
    modelReset();
    #12;
    check("reset_add_r0_r1", outputData, 16'h0020);
    reset_n = 1'b1;

    // Tag 0 right after reset must not write.
    step(8'h00, ADD, 2'd0, 2'd1, 2'd0, 16'h0020, 1'b1, "tag0_hold_a");
    step(8'h00, ADD, 2'd0, 2'd1, 2'd0, 16'h0020, 1'b1, "tag0_hold_b");
    peekAll("after_tag0");

    // ADD chain
    step(8'd1, ADD, 2'd0, 2'd1, 2'd2, 16'h0020, 1'b1, "add1");
    step(8'd2, ADD, 2'd2, 2'd0, 2'd2, 16'h0030, 1'b1, "add2");
    step(8'd3, ADD, 2'd2, 2'd0, 2'd2, 16'h0040, 1'b1, "add3");
    step(8'd4, ADD, 2'd2, 2'd1, 2'd3, 16'h0050, 1'b1, "add4");
    step(8'd5, ADD, 2'd2, 2'd3, 2'd1, 16'h0090, 1'b1, "add5");

    // Negate, subtract, invert
    step(8'd6,  TCP,  2'd0, 2'd0, 2'd0, 16'hfff0, 1'b1, "tcp_r0");
    step(8'd7,  TCP,  2'd1, 2'd0, 2'd1, 16'hff70, 1'b1, "tcp_r1");
    step(8'd8,  SUB,  2'd0, 2'd1, 2'd2, 16'h0080, 1'b1, "sub1");
    step(8'd9,  SUB,  2'd2, 2'd1, 2'd2, 16'h0110, 1'b1, "sub2");
    step(8'd10, NOT_, 2'd2, 2'd0, 2'd2, 16'hfeef, 1'b1, "not_r2");

    // Logic, shift left, overflow wrap
    step(8'd11, AND_, 2'd0, 2'd1, 2'd0, 16'hff70, 1'b1, "and1");
    step(8'd12, AND_, 2'd0, 2'd1, 2'd0, 16'hff70, 1'b1, "and_repeat");
    step(8'd13, SHL,  2'd0, 2'd0, 2'd0, 16'hfee0, 1'b1, "shl_r0");
    step(8'd14, TCP,  2'd0, 2'd0, 2'd3, 16'h0120, 1'b1, "tcp_r3_r0");
    step(8'd15, ADD,  2'd3, 2'd2, 2'd0, 16'h000f, 1'b1, "add_carry_drop");
    step(8'd16, ORR,  2'd0, 2'd0, 2'd0, 16'h000f, 1'b1, "orr_r0");
    step(8'd17, ORR,  2'd3, 2'd3, 2'd3, 16'h0120, 1'b1, "orr_r3");

    // Arithmetic shift right and mixed ops
    step(8'd18, NOT_, 2'd0, 2'd0, 2'd0, 16'hfff0, 1'b1, "not_r0");
    step(8'd19, SHR,  2'd0, 2'd0, 2'd2, 16'hfff8, 1'b1, "shr_r2_r0");
    step(8'd20, SHR,  2'd2, 2'd0, 2'd0, 16'hfffc, 1'b1, "shr_r0_r2");
    step(8'd21, AND_, 2'd0, 2'd2, 2'd1, 16'hfff8, 1'b1, "and_r1");
    step(8'd22, AND_, 2'd1, 2'd1, 2'd2, 16'hfff8, 1'b1, "and_r2");
    step(8'd23, SUB,  2'd1, 2'd0, 2'd3, 16'hfffc, 1'b1, "sub_r3");
    step(8'd24, TCP,  2'd3, 2'd0, 2'd0, 16'h0004, 1'b1, "tcp_r0_r3");
    step(8'd25, ADD,  2'd3, 2'd0, 2'd1, 16'h0000, 1'b1, "add_r1_zero");

    // Tag hold: r2 = fff8 and r0 = 4, so only one increment may land.
    step(8'd26, ADD, 2'd2, 2'd0, 2'd2, 16'hfffc, 1'b1, "hold_1");
    step(8'd26, ADD, 2'd2, 2'd0, 2'd2, 16'h0000, 1'b1, "hold_2");
    step(8'd26, ADD, 2'd2, 2'd0, 2'd2, 16'h0000, 1'b1, "hold_3");

    // Async reset between edges with a write pending for the next edge.
    @(posedge clk);
    #1;
    countOp      = 8'd50;
    functionCode = ADD;
    readReg1     = 2'd0;
    readReg2     = 2'd1;
    writeReg     = 2'd0;
    #1;
    reset_n = 1'b0;
    #1;
    modelReset();
    check("reset_mid_instr", outputData, 16'h0020);
    countOp = 8'h00;
    #1;
    reset_n = 1'b1;
    peekAll("after_async_reset");

    // Unary with unknown readReg2.
    @(posedge clk);
    #1;
    functionCode = NOT_;
    readReg1     = 2'd2;
    readReg2     = 2'bxx;
    #1;
    check("not_x_operand", outputData, 16'hffef);

    // Randomized run starting near the top of the tag range so it wraps.
    tag = 8'hf4;
    for (int n = 0; n < 48; n++) begin
      if ($urandom_range(0, 3) != 0) tag = tag + 8'd1;
      fc = 3'($urandom_range(0, 7));
      ra = 2'($urandom_range(0, 3));
      rb = 2'($urandom_range(0, 3));
      wr = 2'($urandom_range(0, 3));
      step(tag, fc, ra, rb, wr, 16'h0000, 1'b0, $sformatf("rand%0d", n));
    end
    peekAll("after_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
